// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared state encodings and default addresses for the fetch-stage PC sequencer.
package pc_sequencer_pkg;
    typedef enum logic [1:0] {
        PCSEQ_IDLE  = 2'd0,
        PCSEQ_REQ   = 2'd1,
        PCSEQ_HAVE  = 2'd2,
        PCSEQ_DRAIN = 2'd3
    } pcseq_state_e;
    localparam logic [31:0] RESET_PC_DFLT   = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR_DFLT = 32'h0000_4180;
endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: next-PC priority mux (flush, pending redirect, D-stage redirect, sequential +4).
module pc_next_sel (
    input  logic        flush,
    input  logic [31:0] flush_target,
    input  logic        pend_valid,
    input  logic [31:0] pend_target,
    input  logic        d_redirect,
    input  logic [31:0] d_target,
    input  logic [31:0] pc,
    output logic [31:0] next_pc
);
    assign next_pc = flush      ? flush_target :
                     pend_valid ? pend_target  :
                     d_redirect ? d_target     : pc + 32'd4;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: F-stage PC register and imem handshake with delay-slot-correct redirects.
// Optional exception/eret flush support is enabled by defining EXC_EN.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DFLT
`ifdef EXC_EN
    ,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DFLT
`endif
) (
    input  logic        clk,
    input  logic        reset_n,
`ifdef EXC_EN
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
`endif
    input  logic        d_redirect,
    input  logic [31:0] d_target,
    input  logic        f_ready,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        f_valid,
    output logic [31:0] f_instr,
    output logic [31:0] f_pc
);
    pcseq_state_e state, state_next;
    logic [31:0] next_pc, pend_target, flush_target;
    logic        pend_valid, transfer, flush;

    assign transfer = state == PCSEQ_HAVE && f_ready;
    assign f_valid  = state == PCSEQ_HAVE;
    assign imem_req = state == PCSEQ_REQ || state == PCSEQ_DRAIN;

`ifdef EXC_EN
    logic [31:0] drain_addr;
    assign flush        = exc_req || eret_req;
    assign flush_target = exc_req ? EXC_VECTOR : epc;
    // f_pc already points at the flush target while draining, so the old address is kept here
    assign imem_addr    = state == PCSEQ_DRAIN ? drain_addr : f_pc;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            drain_addr <= RESET_PC;
        else if (state == PCSEQ_REQ && flush && !imem_ack)
            drain_addr <= f_pc;
    end
`else
    assign flush        = 1'b0;
    assign flush_target = '0;
    assign imem_addr    = f_pc;
`endif

    pc_next_sel u_next_sel (
        .flush        (flush),
        .flush_target (flush_target),
        .pend_valid   (pend_valid),
        .pend_target  (pend_target),
        .d_redirect   (d_redirect),
        .d_target     (d_target),
        .pc           (f_pc),
        .next_pc      (next_pc)
    );

    always_comb begin
        state_next = state;
        case (state)
            PCSEQ_IDLE:  state_next = PCSEQ_REQ;
            PCSEQ_REQ:   state_next = flush ? (imem_ack ? PCSEQ_REQ : PCSEQ_DRAIN)
                                            : (imem_ack ? PCSEQ_HAVE : PCSEQ_REQ);
            PCSEQ_HAVE:  state_next = (flush || f_ready) ? PCSEQ_REQ : PCSEQ_HAVE;
`ifdef EXC_EN
            PCSEQ_DRAIN: state_next = imem_ack ? PCSEQ_REQ : PCSEQ_DRAIN;
`endif
            default:     state_next = PCSEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= PCSEQ_IDLE;
            f_pc        <= RESET_PC;
            f_instr     <= '0;
            pend_valid  <= 1'b0;
            pend_target <= '0;
        end else begin
            state <= state_next;
            if (flush || transfer)
                f_pc <= next_pc;
            if (state == PCSEQ_REQ && imem_ack && !flush)
                f_instr <= imem_rdata;
            // a redirect seen before its delay slot is handed over waits here
            if (flush || transfer)
                pend_valid <= 1'b0;
            else if (d_redirect) begin
                pend_valid  <= 1'b1;
                pend_target <= d_target;
            end
        end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: table-driven directed vectors plus hand sequences for pc_sequencer.
module tb_pc_sequencer;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        d_redirect = 1'b0;
    logic [31:0] d_target = '0;
    logic        f_ready = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        f_valid;
    logic [31:0] f_instr;
    logic [31:0] f_pc;
`ifdef EXC_EN
    logic        exc_req = 1'b0;
    logic        eret_req = 1'b0;
    logic [31:0] epc = '0;
`endif

    int vectors = 0;
    int miscompares = 0;

    pc_sequencer dut (
        .clk        (clk),
        .reset_n    (reset_n),
`ifdef EXC_EN
        .exc_req    (exc_req),
        .eret_req   (eret_req),
        .epc        (epc),
`endif
        .d_redirect (d_redirect),
        .d_target   (d_target),
        .f_ready    (f_ready),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .f_valid    (f_valid),
        .f_instr    (f_instr),
        .f_pc       (f_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        red;
        logic [31:0] tgt;
        logic        rdy;
        logic        ack;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic rs, input logic red, input logic [31:0] tgt,
                                input logic rdy, input logic ack, input logic [31:0] rd,
                                input logic er, input logic [31:0] ea, input logic ev,
                                input logic [31:0] ep, input logic [31:0] ei);
        vec_t v;
        v.rst_n = rs; v.red = red; v.tgt = tgt; v.rdy = rdy; v.ack = ack; v.rdata = rd;
        v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep; v.e_instr = ei;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input logic er, input logic [31:0] ea,
                       input logic ev, input logic [31:0] ep, input logic [31:0] ei);
        vectors++;
        if (imem_req !== er || imem_addr !== ea || f_valid !== ev || f_pc !== ep || f_instr !== ei) begin
            miscompares++;
            $display("FAIL %s: got req=%b addr=%h valid=%b pc=%h instr=%h, want req=%b addr=%h valid=%b pc=%h instr=%h",
                     name, imem_req, imem_addr, f_valid, f_pc, f_instr, er, ea, ev, ep, ei);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
        $fatal(1);
    end

    initial begin
        int n;
        // rst, redirect, target, ready, ack, rdata | req, addr, valid, pc, instr
        add(0,0,32'h0,0,0,32'h0,               0,32'h3000,0,32'h3000,32'h0);
        add(1,0,32'h0,0,0,32'h0,               0,32'h3000,0,32'h3000,32'h0);
        add(1,0,32'h0,0,0,32'h0,               1,32'h3000,0,32'h3000,32'h0);
        add(1,0,32'h0,0,1,32'hAAAA0000,        1,32'h3000,0,32'h3000,32'h0);
        add(1,0,32'h0,1,0,32'h0,               0,32'h3000,1,32'h3000,32'hAAAA0000);
        add(1,0,32'h0,0,1,32'hBBBB0004,        1,32'h3004,0,32'h3004,32'hAAAA0000);
        for (int i = 0; i < 5; i++)
            add(1,0,32'h0,0,0,32'h0,           0,32'h3004,1,32'h3004,32'hBBBB0004);
        add(1,0,32'h0,1,0,32'h0,               0,32'h3004,1,32'h3004,32'hBBBB0004);
        add(1,0,32'h0,0,1,32'hCCCC0008,        1,32'h3008,0,32'h3008,32'hBBBB0004);
        add(1,1,32'h3400,1,0,32'h0,            0,32'h3008,1,32'h3008,32'hCCCC0008);
        add(1,0,32'h0,0,0,32'h0,               1,32'h3400,0,32'h3400,32'hCCCC0008);
        add(1,0,32'h0,0,1,32'hDDDD3400,        1,32'h3400,0,32'h3400,32'hCCCC0008);
        add(1,1,32'h3800,0,0,32'h0,            0,32'h3400,1,32'h3400,32'hDDDD3400);
        add(1,0,32'h0,1,0,32'h0,               0,32'h3400,1,32'h3400,32'hDDDD3400);
        add(1,0,32'h0,0,1,32'hEEEE3800,        1,32'h3800,0,32'h3800,32'hDDDD3400);
        add(1,0,32'h0,1,0,32'h0,               0,32'h3800,1,32'h3800,32'hEEEE3800);
        add(1,1,32'h3400,0,0,32'h0,            1,32'h3804,0,32'h3804,32'hEEEE3800);
        add(1,0,32'h0,0,0,32'h0,               1,32'h3804,0,32'h3804,32'hEEEE3800);
        add(1,0,32'h0,0,0,32'h0,               1,32'h3804,0,32'h3804,32'hEEEE3800);
        add(1,0,32'h0,0,1,32'h11113804,        1,32'h3804,0,32'h3804,32'hEEEE3800);
        add(1,0,32'h0,1,0,32'h0,               0,32'h3804,1,32'h3804,32'h11113804);
        add(1,0,32'h0,0,1,32'h22223400,        1,32'h3400,0,32'h3400,32'h11113804);
        add(0,0,32'h0,0,1,32'h55555555,        0,32'h3000,0,32'h3000,32'h0);
        add(1,0,32'h0,0,0,32'h0,               0,32'h3000,0,32'h3000,32'h0);
        add(1,0,32'h0,0,0,32'h0,               1,32'h3000,0,32'h3000,32'h0);
        add(1,0,32'h0,0,1,32'h33333000,        1,32'h3000,0,32'h3000,32'h0);
        add(1,1,32'hFFFFFFFC,1,0,32'h0,        0,32'h3000,1,32'h3000,32'h33333000);
        add(1,0,32'h0,0,1,32'h44444444,        1,32'hFFFFFFFC,0,32'hFFFFFFFC,32'h33333000);
        add(1,0,32'h0,1,0,32'h0,               0,32'hFFFFFFFC,1,32'hFFFFFFFC,32'h44444444);
        add(1,0,32'h0,0,0,32'h0,               1,32'h0,0,32'h0,32'h44444444);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            reset_n    = tbl[i].rst_n;
            d_redirect = tbl[i].red;
            d_target   = tbl[i].tgt;
            f_ready    = tbl[i].rdy;
            imem_ack   = tbl[i].ack;
            imem_rdata = tbl[i].rdata;
            #1;
            chk($sformatf("row%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_valid,
                tbl[i].e_pc, tbl[i].e_instr);
        end

        // fresh reset: first request must appear exactly one cycle after release
        @(negedge clk);
        reset_n = 1'b0; d_redirect = 1'b0; f_ready = 1'b0; imem_ack = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        n = 0;
        while (!imem_req && n < 8) begin
            @(negedge clk);
            #1;
            n++;
        end
        vectors++;
        if (n != 1) begin
            miscompares++;
            $display("FAIL first_req_latency: got %0d cycles, want 1", n);
        end
        chk("restart_addr", 1'b1, 32'h3000, 1'b0, 32'h3000, 32'h0);

`ifdef EXC_EN
        @(negedge clk);
        exc_req = 1'b1;
        #1;
        chk("exc_in_req", 1'b1, 32'h3000, 1'b0, 32'h3000, 32'h0);
        @(negedge clk);
        exc_req = 1'b0;
        #1;
        chk("drain_hold", 1'b1, 32'h3000, 1'b0, 32'h4180, 32'h0);
        @(negedge clk);
        imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;
        #1;
        chk("drain_ack", 1'b1, 32'h3000, 1'b0, 32'h4180, 32'h0);
        @(negedge clk);
        imem_ack = 1'b0;
        #1;
        chk("exc_vector_req", 1'b1, 32'h4180, 1'b0, 32'h4180, 32'h0);
        @(negedge clk);
        imem_ack = 1'b1; imem_rdata = 32'h66664180;
        #1;
        chk("exc_vector_ack", 1'b1, 32'h4180, 1'b0, 32'h4180, 32'h0);
        @(negedge clk);
        imem_ack = 1'b0; eret_req = 1'b1; epc = 32'h3024;
        #1;
        chk("eret_in_have", 1'b0, 32'h4180, 1'b1, 32'h4180, 32'h66664180);
        @(negedge clk);
        eret_req = 1'b0;
        #1;
        chk("eret_target", 1'b1, 32'h3024, 1'b0, 32'h3024, 32'h66664180);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
